risc_writeback_regfile: RTL and testbench

//  Producer end of the WB->ID forwarding path: EX->WB pipeline register, write-back result mux and
//  2-read/1-write register file. Drives RW/DA/bus_D to the operand forwarding unit and ID operand muxes.

---
 rtl/risc_pkg.sv | 12 +
 rtl/risc_regfile.sv | 41 ++++
 rtl/risc_writeback_regfile.sv | 48 ++++
 tb/tb_risc_writeback_regfile.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared result-select encodings, default widths and the zero-register index
package risc_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO = 0;
  typedef enum logic [1:0] {
    MD_F   = 2'b00,
    MD_MEM = 2'b01,
    MD_SLT = 2'b10,
    MD_RSV = 2'b11
  } md_e;
endpackage

// File: rtl/risc_regfile.sv
// risc_regfile: 2 async reads / 1 sync write register file, R0 reads zero; RF_WRITE_THROUGH_EN bypasses the write port to reads
module risc_regfile
  import risc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra_a,
  input  logic [ADDR_W-1:0] ra_b,
  output logic [WIDTH-1:0]  rd_a,
  output logic [WIDTH-1:0]  rd_b
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
  logic [WIDTH-1:0] regs [1:2**ADDR_W-1];
  logic [WIDTH-1:0] st_a, st_b;
  logic             wr;
  assign wr = we && wa != ZERO;
  // storage: cleared on reset, R0 has no backing register
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 1; i < 2**ADDR_W; i++) regs[i] <= '0;
    else if (wr)
      regs[wa] <= wd;
  // read ports: stored value, optionally overridden by the word being written this cycle
  always_comb begin
    st_a = ra_a == ZERO ? '0 : regs[ra_a];
    st_b = ra_b == ZERO ? '0 : regs[ra_b];
`ifdef RF_WRITE_THROUGH_EN
    rd_a = wr && ra_a == wa ? wd : st_a;
    rd_b = wr && ra_b == wa ? wd : st_b;
`else
    rd_a = st_a;
    rd_b = st_b;
`endif
  end
endmodule

// File: rtl/risc_writeback_regfile.sv
// risc_writeback_regfile: EX->WB register, result mux, bubble insertion and register file (RF_WRITE_THROUGH_EN selects write-through reads)
module risc_writeback_regfile
  import risc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_RW,
  input  logic [ADDR_W-1:0] ex_DA,
  input  logic [1:0]        ex_MD,
  input  logic [WIDTH-1:0]  ex_F,
  input  logic              ex_N,
  input  logic              ex_V,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  output logic [WIDTH-1:0]  A_data,
  output logic [WIDTH-1:0]  B_data,
  output logic              RW,
  output logic [ADDR_W-1:0] DA,
  output logic [WIDTH-1:0]  bus_D
);
  logic [WIDTH-1:0] result;
  // result select; the reserved encoding falls back to the ALU result
  always_comb
    result = ex_MD == MD_MEM ? mem_data :
             ex_MD == MD_SLT ? {{(WIDTH-1){1'b0}}, ex_N ^ ex_V} : ex_F;
  // WB stage register; stall or flush turn the slot into a bubble by dropping the write enable
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      RW <= 1'b0;
      DA <= '0;
      bus_D <= '0;
    end else begin
      RW <= ex_valid & ex_RW & ~stall & ~flush;
      DA <= ex_DA;
      bus_D <= result;
    end
  risc_regfile #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_rf (
    .clk(clk), .rst(reset), .we(RW), .wa(DA), .wd(bus_D),
    .ra_a(AA), .ra_b(BA), .rd_a(A_data), .rd_b(B_data)
  );
endmodule

// File: tb/tb_risc_writeback_regfile.sv
// tb_risc_writeback_regfile: directed checks of the WB register, result mux, bubbles and register file
module tb_risc_writeback_regfile;
  logic        clk = 0, reset = 1;
  logic        ex_valid = 0, ex_RW = 0, ex_N = 0, ex_V = 0, stall = 0, flush = 0;
  logic [4:0]  ex_DA = 0, AA = 0, BA = 0, DA;
  logic [1:0]  ex_MD = 0;
  logic [31:0] ex_F = 0, mem_data = 0, A_data, B_data, bus_D;
  logic        RW;
  int total = 0, bad = 0;

  risc_writeback_regfile dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_RW(ex_RW), .ex_DA(ex_DA),
    .ex_MD(ex_MD), .ex_F(ex_F), .ex_N(ex_N), .ex_V(ex_V), .mem_data(mem_data),
    .stall(stall), .flush(flush), .AA(AA), .BA(BA), .A_data(A_data), .B_data(B_data),
    .RW(RW), .DA(DA), .bus_D(bus_D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [4:0] da, input logic [1:0] md, input logic [31:0] f);
    ex_valid = 1; ex_RW = 1; ex_DA = da; ex_MD = md; ex_F = f;
  endtask

  task automatic idle();
    ex_valid = 0; ex_RW = 0; ex_MD = 0; ex_F = 0; ex_DA = 0;
  endtask

  initial begin
    tick(); tick();
    chk("reset_RW", {31'b0, RW}, 0);
    chk("reset_bus_D", bus_D, 0);
    reset = 0;
    // ALU write to R5
    ex(5, 2'b00, 32'h1234);
    tick();
    chk("alu_RW", {31'b0, RW}, 1);
    chk("alu_DA", {27'b0, DA}, 5);
    chk("alu_bus_D", bus_D, 32'h1234);
    idle(); AA = 5; #1;
`ifdef RF_WRITE_THROUGH_EN
    chk("alu_overlap_read", A_data, 32'h1234);
`else
    chk("alu_overlap_read", A_data, 0);
`endif
    tick();
    chk("alu_wb_RW_clear", {31'b0, RW}, 0);
    chk("alu_read_R5", A_data, 32'h1234);
    // result mux: SLT, SLT, memory, reserved
    ex(10, 2'b10, 32'hFFFF_0000); ex_N = 1; ex_V = 0;
    tick();
    chk("slt_n1v0", bus_D, 1);
    ex(11, 2'b10, 32'hFFFF_0000); ex_N = 1; ex_V = 1;
    tick();
    chk("slt_n1v1", bus_D, 0);
    ex(12, 2'b01, 32'h0000_0042); mem_data = 32'hDEADBEEF; ex_N = 0; ex_V = 0;
    tick();
    chk("mem_bus_D", bus_D, 32'hDEADBEEF);
    ex(13, 2'b11, 32'h0000_0055);
    tick();
    chk("md11_bus_D", bus_D, 32'h55);
    idle();
    tick();
    AA = 10; BA = 11; #1;
    chk("slt_R10", A_data, 1);
    chk("slt_R11", B_data, 0);
    AA = 12; BA = 13; #1;
    chk("mem_R12", A_data, 32'hDEADBEEF);
    chk("md11_R13", B_data, 32'h55);
    // write to R0 is carried but never stored
    ex(0, 2'b00, 32'hFFFF_FFFF); AA = 0;
    tick();
    chk("r0_RW", {31'b0, RW}, 1);
    chk("r0_bus_D", bus_D, 32'hFFFF_FFFF);
    chk("r0_overlap_read", A_data, 0);
    idle();
    tick();
    chk("r0_read", A_data, 0);
    // bubbles: stall, flush, both, and invalid slot
    ex(7, 2'b00, 32'h77); stall = 1;
    tick();
    chk("stall_RW", {31'b0, RW}, 0);
    stall = 0; flush = 1;
    tick();
    chk("flush_RW", {31'b0, RW}, 0);
    stall = 1;
    tick();
    chk("stall_flush_RW", {31'b0, RW}, 0);
    stall = 0; flush = 0; ex_valid = 0;
    tick();
    chk("invalid_RW", {31'b0, RW}, 0);
    idle(); AA = 7;
    tick();
    chk("bubble_R7", A_data, 0);
    // same-cycle read of the register being written
    ex(9, 2'b00, 32'h11);
    tick();
    ex(9, 2'b00, 32'hAA);
    tick();
    idle(); AA = 9; BA = 9; #1;
`ifdef RF_WRITE_THROUGH_EN
    chk("wt_A", A_data, 32'hAA);
    chk("wt_B", B_data, 32'hAA);
`else
    chk("wt_A", A_data, 32'h11);
    chk("wt_B", B_data, 32'h11);
`endif
    tick();
    chk("after_wt_R9", A_data, 32'hAA);
    // back-to-back writes to R3
    ex(3, 2'b00, 32'h1);
    tick();
    chk("b2b_first", bus_D, 1);
    ex(3, 2'b00, 32'h2);
    tick();
    chk("b2b_second", bus_D, 2);
    idle(); AA = 3;
    tick();
    chk("b2b_R3", A_data, 2);
    // reset with a write pending in WB
    ex(4, 2'b00, 32'h99);
    tick();
    chk("pre_reset_RW", {31'b0, RW}, 1);
    idle();
    #2 reset = 1; #1;
    chk("rst_RW", {31'b0, RW}, 0);
    chk("rst_DA", {27'b0, DA}, 0);
    chk("rst_bus_D", bus_D, 0);
    tick();
    reset = 0; AA = 4; BA = 5; #1;
    chk("rst_R4", A_data, 0);
    chk("rst_R5", B_data, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
